// File: rtl/spi_slave_ad9512_pkg.sv
// Shared types and constants for the AD9512-style SPI responder.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package ad9512_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INSTR,
        WR,
        RD,
        DONE
    } state_t;

    // Instruction word field positions
    localparam int RW_BIT  = 15;
    localparam int CNT_MSB = 14;
    localparam int CNT_LSB = 13;
    localparam int ADDR_W  = 13;

    // W1W0 byte-count encodings
    localparam logic [1:0] W1W0_ONE    = 2'b00;
    localparam logic [1:0] W1W0_TWO    = 2'b01;
    localparam logic [1:0] W1W0_THREE  = 2'b10;
    localparam logic [1:0] W1W0_STREAM = 2'b11;

    localparam logic [ADDR_W-1:0] UPDATE_ADDR_DEF = 13'h05A;

    // Bytes still to transfer after the first one; streaming is tracked separately
    function automatic logic [1:0] extra_bytes(input logic [1:0] w1w0);
        extra_bytes = 2'd0;
        case (w1w0)
            W1W0_ONE:    extra_bytes = 2'd0;
            W1W0_TWO:    extra_bytes = 2'd1;
            W1W0_THREE:  extra_bytes = 2'd2;
            W1W0_STREAM: extra_bytes = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_slave_ad9512_in_sync.sv
// Synchronises sclk/csb/sdio into clk and produces registered edge strobes.
// Latency: SYNC_STAGES+1 clk from pin to strobe (sdio_s aligned with the strobes).
// Backpressure: none; pins are free-running, clk must be >= 8x sclk. SYNC_STAGES >= 2.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic csb,
    input  logic sdio,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csb_fall,
    output logic csb_rise,
    output logic sdio_s
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] csb_sync;
    logic [SYNC_STAGES-1:0] sdio_sync;
    logic                   sclk_d;
    logic                   csb_d;

    // Synchroniser chains plus registered edge detection; csb resets to its idle-high level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            csb_sync  <= '1;
            sdio_sync <= '0;
            sclk_d    <= 1'b0;
            csb_d     <= 1'b1;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            csb_fall  <= 1'b0;
            csb_rise  <= 1'b0;
            sdio_s    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            csb_sync  <= {csb_sync[SYNC_STAGES-2:0], csb};
            sdio_sync <= {sdio_sync[SYNC_STAGES-2:0], sdio};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            csb_d     <= csb_sync[SYNC_STAGES-1];
            sclk_rise <=  sclk_sync[SYNC_STAGES-1] & ~sclk_d;
            sclk_fall <= ~sclk_sync[SYNC_STAGES-1] &  sclk_d;
            csb_fall  <= ~csb_sync[SYNC_STAGES-1]  &  csb_d;
            csb_rise  <=  csb_sync[SYNC_STAGES-1]  & ~csb_d;
            sdio_s    <= sdio_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/spi_slave_ad9512.sv
// AD9512-style 3-wire SPI responder with shadow/active byte banks and update-register commit.
// Latency: SYNC_STAGES+1 clk pin-to-event; active bank and cfg_update follow the update byte by 1 clk.
// Backpressure: none; the SPI master owns timing, csb rise aborts any transfer in progress.
module spi_slave_ad9512
    import ad9512_spi_pkg::*;
#(
    parameter int                NUM_REGS    = 128,
    parameter logic [ADDR_W-1:0] UPDATE_ADDR = UPDATE_ADDR_DEF,
    parameter int                SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sclk,
    input  logic       spi_csb,
    inout  wire        spi_sdio,
    input  logic [6:0] act_addr,
    output logic [7:0] act_data,
    output logic       cfg_update,
    output logic       xfer_abort
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic sclk_rise, sclk_fall, csb_fall, csb_rise, sdio_s;

    state_t            state, state_nxt;
    logic [3:0]        bit_cnt;
    logic [14:0]       shreg;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        bytes_left;
    logic              stream;
    logic              rd_end;
    logic [7:0]        rd_byte;
    logic              sdo;
    logic              sdio_oe;
    logic [7:0]        shadow [NUM_REGS];
    logic [7:0]        active [NUM_REGS];

    logic [15:0]       instr_word;
    logic [7:0]        wr_byte;
    logic              instr_done, byte_done, more_bytes, wr_commit, abort_c, addr_ok;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (spi_sclk),
        .csb       (spi_csb),
        .sdio      (spi_sdio),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .csb_fall  (csb_fall),
        .csb_rise  (csb_rise),
        .sdio_s    (sdio_s)
    );

    assign spi_sdio = sdio_oe ? sdo : 1'bz;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and per-clk strobes; a csb rise always wins but a completing byte still commits
    always_comb begin
        state_nxt  = state;
        instr_word = {shreg, sdio_s};
        wr_byte    = {shreg[6:0], sdio_s};
        instr_done = 1'b0;
        byte_done  = 1'b0;
        wr_commit  = 1'b0;
        abort_c    = 1'b0;
        more_bytes = stream || (bytes_left != 2'd0);
        addr_ok    = 32'(addr) < NUM_REGS;
        case (state)
            IDLE:  if (csb_fall) state_nxt = INSTR;
            INSTR: if (sclk_rise && bit_cnt == 4'd15) begin
                instr_done = 1'b1;
                state_nxt  = instr_word[RW_BIT] ? RD : WR;
            end
            WR: if (sclk_rise && bit_cnt == 4'd7) begin
                byte_done = 1'b1;
                wr_commit = addr_ok;
                if (!more_bytes) state_nxt = DONE;
            end
            RD: begin
                if (sclk_rise && !rd_end && bit_cnt == 4'd7) byte_done = 1'b1;
                if (sclk_fall && rd_end) state_nxt = DONE;
            end
            DONE:  if (csb_fall) state_nxt = INSTR;
            default: state_nxt = IDLE;
        endcase
        if (csb_rise) begin
            abort_c   = (state == INSTR || state == WR || state == RD) &&
                        bit_cnt != 4'd0 && !byte_done && !instr_done;
            state_nxt = IDLE;
        end
        rd_addr = instr_done ? instr_word[ADDR_W-1:0] : addr - ADDR_W'(1);
        rd_data = (32'(rd_addr) < NUM_REGS) ? shadow[rd_addr[IDX_W-1:0]] : 8'h00;
    end

    // Shift register, address/count tracking and sdio drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= 4'd0;
            shreg      <= '0;
            addr       <= '0;
            bytes_left <= 2'd0;
            stream     <= 1'b0;
            rd_end     <= 1'b0;
            rd_byte    <= 8'h00;
            sdo        <= 1'b0;
            sdio_oe    <= 1'b0;
            xfer_abort <= 1'b0;
        end else begin
            xfer_abort <= abort_c;
            if (csb_fall && (state == IDLE || state == DONE)) begin
                bit_cnt <= 4'd0;
                rd_end  <= 1'b0;
            end
            if (state == INSTR && sclk_rise) begin
                shreg   <= instr_word[14:0];
                bit_cnt <= bit_cnt + 4'd1;
                if (instr_done) begin
                    bit_cnt    <= 4'd0;
                    addr       <= instr_word[ADDR_W-1:0];
                    stream     <= instr_word[CNT_MSB:CNT_LSB] == W1W0_STREAM;
                    bytes_left <= extra_bytes(instr_word[CNT_MSB:CNT_LSB]);
                    rd_byte    <= rd_data;
                end
            end
            if (state == WR && sclk_rise) begin
                shreg   <= {shreg[13:0], sdio_s};
                bit_cnt <= bit_cnt + 4'd1;
                if (byte_done) begin
                    bit_cnt    <= 4'd0;
                    addr       <= addr - ADDR_W'(1);
                    bytes_left <= bytes_left - 2'd1;
                end
            end
            if (state == RD) begin
                if (sclk_rise && !rd_end) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (byte_done) begin
                        bit_cnt    <= 4'd0;
                        addr       <= addr - ADDR_W'(1);
                        bytes_left <= bytes_left - 2'd1;
                        if (more_bytes) rd_byte <= rd_data;
                        else            rd_end  <= 1'b1;
                    end
                end
                if (sclk_fall) begin
                    if (rd_end) begin
                        sdio_oe <= 1'b0;
                    end else begin
                        sdio_oe <= 1'b1;
                        sdo     <= rd_byte[7];
                        rd_byte <= {rd_byte[6:0], 1'b0};
                    end
                end
            end
            if (csb_rise) sdio_oe <= 1'b0;
        end
    end

    // Shadow writes from SPI (update bit0 self-clears); active snapshot one clk after the update byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= 8'h00;
                active[i] <= 8'h00;
            end
            cfg_update <= 1'b0;
        end else begin
            cfg_update <= wr_commit && (addr == UPDATE_ADDR) && wr_byte[0];
            if (wr_commit)
                shadow[addr[IDX_W-1:0]] <= (addr == UPDATE_ADDR) ? {wr_byte[7:1], 1'b0} : wr_byte;
            if (cfg_update)
                for (int i = 0; i < NUM_REGS; i++) active[i] <= shadow[i];
        end
    end

    // Fabric read port into the active bank; shows pre-commit data during the cfg_update clk
    always_comb begin
        act_data = 8'h00;
        if (32'(act_addr) < NUM_REGS) act_data = active[act_addr[IDX_W-1:0]];
    end

endmodule

// File: tb/tb_spi_slave_ad9512.sv
// Bench for spi_slave_ad9512: table of SPI transactions plus hand-written corner sequences.
// Latency: sclk half period is 8 clk, comfortably above the DUT's sync lag.
// Backpressure: none; read bytes are checked against a queue of expected values.
module tb_spi_slave_ad9512;

    localparam int HALF = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       csb = 1'b1;
    logic       tb_oe = 1'b0;
    logic       tb_dout = 1'b0;
    wire        sdio;
    logic [6:0] act_addr = 7'h00;
    logic [7:0] act_data;
    logic       cfg_update, xfer_abort;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int abort_cnt = 0;
    logic [7:0] exp_q[$];

    assign sdio = tb_oe ? tb_dout : 1'bz;

    spi_slave_ad9512 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_sclk   (sclk),
        .spi_csb    (csb),
        .spi_sdio   (sdio),
        .act_addr   (act_addr),
        .act_data   (act_data),
        .cfg_update (cfg_update),
        .xfer_abort (xfer_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cfg_update) upd_cnt++;
        if (xfer_abort) abort_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit        rw;
        bit [1:0]  w1w0;
        bit [12:0] addr;
        int        nb;
        bit [31:0] dat;
        int        exp_upd;
        bit [6:0]  aa;
        bit [7:0]  ad;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bit_out(input logic b);
        sclk = 1'b0; tb_oe = 1'b1; tb_dout = b; #HALF;
        sclk = 1'b1; #HALF;
    endtask

    task automatic bit_in(output logic b);
        sclk = 1'b0; tb_oe = 1'b0; #HALF;
        b = sdio;
        sclk = 1'b1; #HALF;
    endtask

    task automatic send_instr(input logic rw, input logic [1:0] w1w0, input logic [12:0] addr);
        logic [15:0] w;
        w = {rw, w1w0, addr};
        csb = 1'b0; #HALF;
        for (int i = 15; i >= 0; i--) bit_out(w[i]);
    endtask

    task automatic do_write(input logic [1:0] w1w0, input logic [12:0] addr, input int nb,
                            input logic [31:0] dat);
        logic [7:0] d;
        send_instr(1'b0, w1w0, addr);
        for (int k = 0; k < nb; k++) begin
            d = dat[31-8*k -: 8];
            for (int i = 7; i >= 0; i--) bit_out(d[i]);
        end
        sclk = 1'b0; tb_oe = 1'b0; #HALF;
        csb = 1'b1; #(4*HALF);
    endtask

    task automatic do_read(input logic [1:0] w1w0, input logic [12:0] addr, input int nb,
                           input string tag);
        logic [7:0] got, exp;
        logic       b;
        send_instr(1'b1, w1w0, addr);
        chk({tag, " oe_pre"}, dut.sdio_oe, 0);
        for (int k = 0; k < nb; k++) begin
            got = 8'h00;
            for (int i = 0; i < 8; i++) begin
                bit_in(b);
                got = {got[6:0], b};
                if (k == 0 && i == 0) chk({tag, " oe_on"}, dut.sdio_oe, 1);
            end
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL %s rd_byte%0d: got 0x%0h but no expected byte queued", tag, k, got);
            end else begin
                exp = exp_q.pop_front();
                chk($sformatf("%s rd_byte%0d", tag, k), got, exp);
            end
        end
        sclk = 1'b0; #HALF;
        chk({tag, " oe_post"}, dut.sdio_oe, (w1w0 == 2'b11) ? 1 : 0);
        csb = 1'b1; #(4*HALF);
        chk({tag, " oe_csb"}, dut.sdio_oe, 0);
    endtask

    task automatic exp_read(input logic [1:0] w1w0, input logic [12:0] addr, input int nb,
                            input logic [31:0] dat, input string tag);
        for (int k = 0; k < nb; k++) exp_q.push_back(dat[31-8*k -: 8]);
        do_read(w1w0, addr, nb, tag);
    endtask

    initial begin
        int u0, a0;
        logic b;

        //          rw  w1w0   addr     nb  data          upd act_addr act_data
        vt[0]  = '{0, 2'b00, 13'h045, 1, 32'hA5000000, 0, 7'h45, 8'h00};
        vt[1]  = '{1, 2'b00, 13'h045, 1, 32'hA5000000, 0, 7'h45, 8'h00};
        vt[2]  = '{0, 2'b00, 13'h05A, 1, 32'h01000000, 1, 7'h45, 8'hA5};
        vt[3]  = '{1, 2'b00, 13'h05A, 1, 32'h00000000, 0, 7'h5A, 8'h00};
        vt[4]  = '{0, 2'b10, 13'h012, 4, 32'h11223344, 0, 7'h12, 8'h00};
        vt[5]  = '{1, 2'b01, 13'h011, 2, 32'h22330000, 0, 7'h45, 8'hA5};
        vt[6]  = '{1, 2'b00, 13'h00F, 1, 32'h00000000, 0, 7'h0F, 8'h00};
        vt[7]  = '{0, 2'b11, 13'h001, 3, 32'hDEADBE00, 0, 7'h01, 8'h00};
        vt[8]  = '{1, 2'b01, 13'h001, 2, 32'hDEAD0000, 0, 7'h00, 8'h00};
        vt[9]  = '{1, 2'b00, 13'h07F, 1, 32'h00000000, 0, 7'h7F, 8'h00};
        vt[10] = '{1, 2'b11, 13'h012, 3, 32'h11223300, 0, 7'h45, 8'hA5};
        vt[11] = '{0, 2'b00, 13'h05A, 1, 32'h03000000, 1, 7'h12, 8'h11};
        vt[12] = '{1, 2'b00, 13'h05A, 1, 32'h02000000, 0, 7'h01, 8'hDE};
        vt[13] = '{0, 2'b00, 13'h030, 1, 32'h5C000000, 0, 7'h00, 8'hAD};
        vt[14] = '{1, 2'b00, 13'h030, 1, 32'h5C000000, 0, 7'h30, 8'h00};

        // Reset state
        act_addr = 7'h45;
        #33;
        chk("rst act_data", act_data, 8'h00);
        chk("rst cfg_update", cfg_update, 0);
        chk("rst xfer_abort", xfer_abort, 0);
        chk("rst oe", dut.sdio_oe, 0);
        rst_n = 1'b1;
        #40;

        // Table-driven transactions
        for (int r = 0; r < NV; r++) begin
            u0 = upd_cnt;
            a0 = abort_cnt;
            if (vt[r].rw) exp_read(vt[r].w1w0, vt[r].addr, vt[r].nb, vt[r].dat, $sformatf("r%0d", r));
            else          do_write(vt[r].w1w0, vt[r].addr, vt[r].nb, vt[r].dat);
            chk($sformatf("r%0d cfg_update_cnt", r), upd_cnt - u0, vt[r].exp_upd);
            chk($sformatf("r%0d xfer_abort_cnt", r), abort_cnt - a0, 0);
            act_addr = vt[r].aa;
            #10;
            chk($sformatf("r%0d act_data", r), act_data, vt[r].ad);
        end

        // Abort after 5 data bits of a write to 0x030
        u0 = upd_cnt;
        a0 = abort_cnt;
        send_instr(1'b0, 2'b00, 13'h030);
        for (int i = 0; i < 5; i++) bit_out(1'b1);
        sclk = 1'b0; tb_oe = 1'b0; #HALF;
        csb = 1'b1; #(4*HALF);
        chk("abort pulse_cnt", abort_cnt - a0, 1);
        chk("abort cfg_update_cnt", upd_cnt - u0, 0);
        exp_read(2'b00, 13'h030, 1, 32'h5C000000, "abort_rb");

        // csb rise coincident with the 8th data rise still commits the byte
        a0 = abort_cnt;
        send_instr(1'b0, 2'b00, 13'h040);
        for (int i = 7; i >= 1; i--) bit_out(i[0] ^ i[1] ^ i[2]);
        sclk = 1'b0; tb_oe = 1'b1; tb_dout = 1'b0; #HALF;
        sclk = 1'b1; csb = 1'b1; #HALF;
        sclk = 1'b0; tb_oe = 1'b0; #(4*HALF);
        chk("coinc abort_cnt", abort_cnt - a0, 0);
        exp_read(2'b00, 13'h040, 1, 32'h96000000, "coinc_rb");

        // Reset asserted in the middle of a read
        send_instr(1'b1, 2'b00, 13'h045);
        for (int i = 0; i < 3; i++) bit_in(b);
        sclk = 1'b0; #HALF;
        chk("midrd oe_before_rst", dut.sdio_oe, 1);
        act_addr = 7'h45;
        rst_n = 1'b0;
        #1;
        chk("midrd oe_in_rst", dut.sdio_oe, 0);
        chk("midrd act_in_rst", act_data, 8'h00);
        #9;
        csb = 1'b1;
        #20;
        rst_n = 1'b1;
        #(4*HALF);
        exp_read(2'b00, 13'h045, 1, 32'h00000000, "post_rst_45");
        do_write(2'b00, 13'h020, 1, 32'h3C000000);
        exp_read(2'b00, 13'h020, 1, 32'h3C000000, "post_rst_20");
        u0 = upd_cnt;
        do_write(2'b00, 13'h05A, 1, 32'h01000000);
        chk("post_rst cfg_update_cnt", upd_cnt - u0, 1);
        act_addr = 7'h20;
        #10;
        chk("post_rst act_data", act_data, 8'h3C);
        chk("queue drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_ad9512.md
Name: spi_slave_ad9512

Overview:
- Synthesizable 3-wire SPI responder that mimics the AD9512 serial control port, i.e. the far end of our SPI configuration master.
- Used as an on-board loopback target and bench DUT so the configuration master can be exercised without the clock chip.
- Oversamples sclk, csb and sdio in the fabric clock domain and decodes the 16-bit instruction.
- Holds a shadow/active byte register file with the AD9512 update-register transfer, and drives sdio on reads.

Parameters:
- NUM_REGS, 128, number of byte registers; valid addresses are 0 to NUM_REGS-1.
- UPDATE_ADDR, 13'h05A, address of the update register; bit0 commits shadow to active.
- SYNC_STAGES, 2, synchronizer depth on the SPI inputs.

Ports:
- clk  in  1  fabric clock; must be at least 8x the sclk frequency.
- rst_n  in  1  asynchronous active-low reset.
- spi_sclk  in  1  SPI clock from the master; idles low.
- spi_csb  in  1  chip select, active low.
- spi_sdio  inout  1  bidirectional data line; driven only during the read data phase, otherwise Z.
- act_addr  in  7  fabric read address into the active bank.
- act_data  out  8  active-bank byte at act_addr; combinational read; 0 if act_addr is out of range.
- cfg_update  out  1  one-clk pulse when shadow is copied to active.
- xfer_abort  out  1  one-clk pulse when csb rises with a partial byte or instruction pending.

Behaviour:
- Reset:
  - All shadow and active registers = 0x00.
  - cfg_update = 0, xfer_abort = 0, sdio released (oe = 0), FSM = IDLE.
- Input conditioning:
  - sclk, csb and sdio each pass through SYNC_STAGES flip-flops.
  - Rise/fall detect is done on synchronized sclk.
  - Events therefore lag the pins by SYNC_STAGES+1 clk.
- Bit order and sampling:
  - MSB first.
  - Bits are sampled on sclk rise; sdio is updated on sclk fall.
- Instruction word, 16 bits:
  - [15] = R/W, where 1 = read.
  - [14:13] = W1W0 byte count: 00 = 1, 01 = 2, 10 = 3, 11 = streaming until csb rises.
  - [12:0] = start address.
- FSM states and transitions:
  - IDLE: on synchronized csb falling, clear the bit counter and go to INSTR.
  - INSTR: shift 16 bits. On the 16th rise, latch R/W, count and address, then go to WR or RD.
  - WR: shift 8 bits. On the 8th rise, if address < NUM_REGS, write the byte to shadow[addr]; out-of-range writes are dropped. Then decrement the address and the byte count. When the count is exhausted (non-streaming), go to DONE.
  - RD:
    - On the first sclk fall after the instruction, assert oe and drive bit7 of shadow[addr]; out-of-range reads return 0x00.
    - Each subsequent fall drives the next bit.
    - The 8th sclk rise of a byte ends that byte: decrement the address, load the next byte, and continue with its MSB on the next fall.
    - When the count is exhausted, deassert oe on the next fall and go to DONE.
  - DONE: ignore all sclk edges until csb rises.
- Address arithmetic:
  - 13-bit decrement; address 0 wraps to 0x1FFF.
  - A wrapped address is out of range, so writes are ignored and reads return 0.
- Update register:
  - A completed write byte to UPDATE_ADDR with bit0 = 1 copies all shadow registers to active in the next clk.
  - The same clk pulses cfg_update.
  - The stored UPDATE_ADDR bit0 self-clears, so it reads back 0.
  - Other bits of that write are stored normally.
- csb rise in any state:
  - FSM returns to IDLE within 1 clk of the synchronized edge; oe deasserts in the same clk.
  - Partial instruction or data bits are discarded; completed bytes remain committed.
  - xfer_abort pulses if the bit counter was non-zero in INSTR, WR or RD.
- Simultaneous events:
  - If a csb rise coincides with the 8th sclk rise, the byte is committed first, then IDLE.
  - If an update commit and an act_addr read occur in the same clk, act_data shows the pre-commit value.
- sclk edges while csb is high are ignored.
- A csb fall arriving while in DONE restarts at INSTR.

Decomposition:
- Package ad9512_spi_pkg holds:
  - state enum {IDLE, INSTR, WR, RD, DONE};
  - instruction field positions (RW_BIT = 15, CNT_MSB/LSB = 14/13, ADDR_W = 13);
  - the W1W0 encodings;
  - the UPDATE_ADDR default.
- Sub-module spi_in_sync: synchronizer plus edge detector producing sclk_rise, sclk_fall, csb_fall, csb_rise and sdio_s.

Test Plan:
- Write 0x0045 with W1W0 = 00 and data 0xA5 -> shadow[0x45] = 0xA5, active[0x45] still 0x00, no cfg_update.
- Then write 0x5A = 0x01 -> cfg_update pulses once, act_data at 0x45 = 0xA5, read of 0x5A returns 0x00.
- Write W1W0 = 10 at 0x0012 with data 0x11, 0x22, 0x33 -> shadow[0x12] = 0x11, [0x11] = 0x22, [0x10] = 0x33; a 4th byte sent before csb rises is ignored.
- Read W1W0 = 01 at 0x0011 -> sdio returns 0x22 then 0x33 MSB-first on falls; oe is low before the first fall and after the 16th data bit.
- Streaming write at 0x0001 with 0xDE, 0xAD, 0xBE -> [1] = 0xDE, [0] = 0xAD, wrap to 0x1FFF drops 0xBE; no other register changes.
- Drive csb high after 5 data bits of a write to 0x0030 -> shadow[0x30] unchanged, xfer_abort pulses, FSM back in IDLE.
- Assert rst_n low mid-read -> sdio released immediately, registers = 0.
- A following transaction after reset completes normally.
